// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
// Request/response payloads, arbiter FSM states and configuration defaults.
package mem_arb_pkg;

   localparam int MEM_ARB_N_REQ     = 2;
   localparam int MEM_ARB_MAX_OUTST = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } mem_resp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   // Width of an index into n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_idfifo.sv
// Synchronous FIFO holding the requester IDs of in-flight transactions.
// Pointers wrap at DEPTH; the count covers 0..DEPTH.
module mem_arb_idfifo
   import mem_arb_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_count == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter of N_REQ masters onto one memory port with in-order response routing.
// Build option MEM_ARB_DBG_PRIO_EN gives requester 0 (debug) absolute priority when idle.
//
//  state    | meaning
//  ARB_IDLE | arbitrate; zero-latency pass-through when downstream is ready
//  ARB_HOLD | downstream stalled; grant frozen on r_gnt_id until accepted
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int N_REQ     = MEM_ARB_N_REQ,
   parameter int MAX_OUTST = MEM_ARB_MAX_OUTST
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   output logic [N_REQ-1:0]              req_ready_o,
   input  mem_req_t                      req_i [N_REQ],
   output logic [N_REQ-1:0]              resp_valid_o,
   input  logic [N_REQ-1:0]              resp_ready_i,
   output mem_resp_t                     resp_o,
   output logic                          mem_req_valid_o,
   input  logic                          mem_req_ready_i,
   output mem_req_t                      mem_req_o,
   input  logic                          mem_resp_valid_i,
   output logic                          mem_resp_ready_o,
   input  mem_resp_t                     mem_resp_i,
   output logic [$clog2(MAX_OUTST):0]    outst_cnt_o,
   output logic                          busy_o
);

   localparam int ID_W  = clog2_min1(N_REQ);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [ID_W-1:0]  w_rr_nxt;
   logic [ID_W-1:0]  r_gnt_id;
   logic [ID_W-1:0]  w_gnt_nxt;
   logic [ID_W-1:0]  w_win;
   logic             w_any;
   logic             w_push;
   logic [ID_W-1:0]  w_push_id;
   logic             w_pop;
   logic [ID_W-1:0]  w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;

   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
      return (int'(id) >= N_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   // Winner search; the debug build keeps rr_ptr meaningful only over 1..N_REQ-1.
   always_comb begin
      int              k;
      logic [ID_W-1:0] idx;
      w_any = 1'b0;
      w_win = '0;
      k     = 0;
      idx   = '0;
`ifdef MEM_ARB_DBG_PRIO_EN
      if (req_valid_i[0]) begin
         w_any = 1'b1;
      end else begin
         for (int i = 0; i < N_REQ - 1; i++) begin
            k = ((r_rr_ptr == '0) ? 1 : int'(r_rr_ptr)) + i;
            if (k >= N_REQ) k = k - (N_REQ - 1);
            idx = ID_W'(k);
            if (!w_any && req_valid_i[idx]) begin
               w_any = 1'b1;
               w_win = idx;
            end
         end
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         k = int'(r_rr_ptr) + i;
         if (k >= N_REQ) k = k - N_REQ;
         idx = ID_W'(k);
         if (!w_any && req_valid_i[idx]) begin
            w_any = 1'b1;
            w_win = idx;
         end
      end
`endif
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_nxt        = r_rr_ptr;
      w_gnt_nxt       = r_gnt_id;
      w_push          = 1'b0;
      w_push_id       = '0;
      req_ready_o     = '0;
      mem_req_valid_o = 1'b0;
      mem_req_o       = '0;
      if (rstn_i) begin
         case (r_state)
            ARB_IDLE: begin
               // Full blocks a grant even when a pop lands this cycle: no ready-to-ready path.
               if (!w_full && w_any) begin
                  mem_req_valid_o = 1'b1;
                  mem_req_o       = req_i[w_win];
                  if (mem_req_ready_i) begin
                     req_ready_o[w_win] = 1'b1;
                     w_push             = 1'b1;
                     w_push_id          = w_win;
                     w_rr_nxt           = rr_next(w_win);
                  end else begin
                     w_gnt_nxt   = w_win;
                     w_state_nxt = ARB_HOLD;
                  end
               end
            end
            ARB_HOLD: begin
               mem_req_valid_o = 1'b1;
               mem_req_o       = req_i[r_gnt_id];
               if (mem_req_ready_i) begin
                  req_ready_o[r_gnt_id] = 1'b1;
                  w_push                = 1'b1;
                  w_push_id             = r_gnt_id;
                  w_rr_nxt              = rr_next(r_gnt_id);
                  w_state_nxt           = ARB_IDLE;
               end
            end
            default: w_state_nxt = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state  <= ARB_IDLE;
         r_rr_ptr <= '0;
         r_gnt_id <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_gnt_id <= w_gnt_nxt;
      end
   end

   mem_arb_idfifo #(
      .W     (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_idfifo (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .push_i      (w_push),
      .push_data_i (w_push_id),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .count_o     (w_count)
   );

   always_comb begin
      resp_valid_o = '0;
      if (rstn_i && !w_empty) resp_valid_o[w_head] = mem_resp_valid_i;
   end

   assign mem_resp_ready_o = rstn_i & ~w_empty & resp_ready_i[w_head];
   assign w_pop            = mem_resp_valid_i & mem_resp_ready_o;
   assign resp_o           = mem_resp_i;
   assign outst_cnt_o      = rstn_i ? w_count : '0;
   assign busy_o           = rstn_i & ((w_count != '0) | (r_state == ARB_HOLD));

`ifndef SYNTHESIS
   // A granted requester must keep valid asserted until the downstream accepts.
   a_hold_valid : assert property (@(posedge clk_i) disable iff (!rstn_i)
      (r_state == ARB_HOLD) |-> req_valid_i[r_gnt_id]);
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: stimulus queues expected grants/responses, a monitor checks them.
// Expected grant order follows MEM_ARB_DBG_PRIO_EN when defined.
module tb_mem_arb;
   import mem_arb_pkg::*;

   logic        clk_i;
   logic        rstn_i;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   mem_req_t    req_i [2];
   logic [1:0]  resp_valid_o;
   logic [1:0]  resp_ready_i;
   mem_resp_t   resp_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   mem_req_t    mem_req_o;
   logic        mem_resp_valid_i;
   logic        mem_resp_ready_o;
   mem_resp_t   mem_resp_i;
   logic [1:0]  outst_cnt_o;
   logic        busy_o;

   mem_arb dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_i            (req_i),
      .resp_valid_o     (resp_valid_o),
      .resp_ready_i     (resp_ready_i),
      .resp_o           (resp_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_req_o        (mem_req_o),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_ready_o (mem_resp_ready_o),
      .mem_resp_i       (mem_resp_i),
      .outst_cnt_o      (outst_cnt_o),
      .busy_o           (busy_o)
   );

   typedef struct {
      int          id;
      logic [31:0] val;
   } exp_t;

   exp_t q_grant[$];
   exp_t q_resp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Monitor: every accepted request / response is matched against the queue head.
   always @(negedge clk_i) begin
      exp_t       e;
      logic [1:0] oh;
      if (mem_req_valid_o && mem_req_ready_i) begin
         if (q_grant.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_unexpected: got req_ready_o=%b with no grant expected", req_ready_o);
         end else begin
            e = q_grant.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            chk("grant_ready", 64'(req_ready_o), 64'(oh));
            chk("grant_addr", 64'(mem_req_o.addr), 64'(e.val));
         end
      end
      if (mem_resp_valid_i && mem_resp_ready_o) begin
         if (q_resp.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got resp_valid_o=%b with no response expected", resp_valid_o);
         end else begin
            e = q_resp.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            chk("resp_route", 64'(resp_valid_o), 64'(oh));
            chk("resp_data", 64'(resp_o.rdata), 64'(e.val));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [1:0] pat [6];
      int         gseq [6];
      pat = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
`ifdef MEM_ARB_DBG_PRIO_EN
      gseq = '{0, 0, 0, 0, 1, 0};
`else
      gseq = '{0, 1, 0, 1, 1, 0};
`endif

      // Reset with both requesters valid: everything must stay quiet.
      rstn_i           = 1'b0;
      req_valid_i      = 2'b11;
      req_i[0]         = '{addr: 32'h2000, wdata: 32'h0, be: 4'hf, we: 1'b0};
      req_i[1]         = '{addr: 32'h3000, wdata: 32'h0, be: 4'hf, we: 1'b0};
      mem_req_ready_i  = 1'b1;
      mem_resp_valid_i = 1'b0;
      mem_resp_i       = '0;
      resp_ready_i     = 2'b11;
      @(negedge clk_i);
      chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'(0));
      chk("rst_req_ready", 64'(req_ready_o), 64'(0));
      chk("rst_outst", 64'(outst_cnt_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_resp_ready", 64'(mem_resp_ready_o), 64'(0));

      // Single read from requester 1, response next cycle.
      tick();
      rstn_i      = 1'b1;
      req_valid_i = 2'b10;
      req_i[1].addr = 32'h1000;
      q_grant.push_back('{id: 1, val: 32'h1000});
      @(negedge clk_i);
      chk("s1_outst0", 64'(outst_cnt_o), 64'(0));
      tick();
      req_valid_i        = 2'b00;
      mem_resp_valid_i   = 1'b1;
      mem_resp_i.rdata   = 32'hDEADBEEF;
      q_resp.push_back('{id: 1, val: 32'hDEADBEEF});
      @(negedge clk_i);
      chk("s1_outst1", 64'(outst_cnt_o), 64'(1));
      chk("s1_busy", 64'(busy_o), 64'(1));
      tick();
      mem_resp_valid_i = 1'b0;
      @(negedge clk_i);
      chk("s1_outst_end", 64'(outst_cnt_o), 64'(0));
      chk("s1_busy_end", 64'(busy_o), 64'(0));

      // Back-to-back requests with immediate responses.
      req_i[1].addr = 32'h3000;
      for (int k = 0; k <= 6; k++) begin
         tick();
         req_valid_i = (k < 6) ? pat[k] : 2'b00;
         if (k < 6) q_grant.push_back('{id: gseq[k], val: (gseq[k] == 0) ? 32'h2000 : 32'h3000});
         mem_resp_valid_i = (k > 0);
         if (k > 0) begin
            mem_resp_i.rdata = 32'hA000_0000 + 32'(k - 1);
            q_resp.push_back('{id: gseq[k-1], val: 32'hA000_0000 + 32'(k - 1)});
         end
         @(negedge clk_i);
         chk("s2_outst", 64'(outst_cnt_o), 64'((k == 0) ? 0 : 1));
      end
      tick();
      mem_resp_valid_i = 1'b0;
      @(negedge clk_i);
      chk("s2_outst_end", 64'(outst_cnt_o), 64'(0));

      // Stalled write from requester 0 while requester 1 competes.
      req_i[0] = '{addr: 32'h4000, wdata: 32'h1234_5678, be: 4'hf, we: 1'b1};
      tick();
      req_valid_i     = 2'b01;
      mem_req_ready_i = 1'b0;
      @(negedge clk_i);
      chk("s3_valid_c0", 64'(mem_req_valid_o), 64'(1));
      chk("s3_ready_c0", 64'(req_ready_o), 64'(0));
      chk("s3_addr_c0", 64'(mem_req_o.addr), 64'(32'h4000));
      chk("s3_we_c0", 64'(mem_req_o.we), 64'(1));
      for (int c = 1; c <= 2; c++) begin
         tick();
         req_valid_i = 2'b11;
         @(negedge clk_i);
         chk("s3_hold_valid", 64'(mem_req_valid_o), 64'(1));
         chk("s3_hold_ready", 64'(req_ready_o), 64'(0));
         chk("s3_hold_addr", 64'(mem_req_o.addr), 64'(32'h4000));
         chk("s3_hold_wdata", 64'(mem_req_o.wdata), 64'(32'h1234_5678));
         chk("s3_hold_busy", 64'(busy_o), 64'(1));
      end
      tick();
      mem_req_ready_i = 1'b1;
      q_grant.push_back('{id: 0, val: 32'h4000});
      @(negedge clk_i);
      tick();
      req_valid_i = 2'b10;
      q_grant.push_back('{id: 1, val: 32'h3000});
      @(negedge clk_i);
      chk("s3_outst1", 64'(outst_cnt_o), 64'(1));

      // FIFO full: third request must wait, response stall and routing.
      tick();
      req_valid_i = 2'b01;
      @(negedge clk_i);
      chk("s4_full_valid", 64'(mem_req_valid_o), 64'(0));
      chk("s4_full_ready", 64'(req_ready_o), 64'(0));
      chk("s4_outst2", 64'(outst_cnt_o), 64'(2));
      tick();
      mem_resp_valid_i = 1'b1;
      mem_resp_i.rdata = 32'hAAAA_0001;
      resp_ready_i     = 2'b10;
      @(negedge clk_i);
      chk("s4_stall_resp_ready", 64'(mem_resp_ready_o), 64'(0));
      chk("s4_stall_resp_valid", 64'(resp_valid_o), 64'(2'b01));
      chk("s4_stall_full", 64'(mem_req_valid_o), 64'(0));
      tick();
      resp_ready_i = 2'b11;
      q_resp.push_back('{id: 0, val: 32'hAAAA_0001});
      @(negedge clk_i);
      chk("s4_pop_full", 64'(mem_req_valid_o), 64'(0));
      tick();
      mem_resp_i.rdata = 32'hBBBB_0002;
      q_resp.push_back('{id: 1, val: 32'hBBBB_0002});
      q_grant.push_back('{id: 0, val: 32'h4000});
      @(negedge clk_i);
      chk("s4_outst_pp", 64'(outst_cnt_o), 64'(1));
      tick();
      req_valid_i      = 2'b00;
      mem_resp_i.rdata = 32'hCCCC_0003;
      q_resp.push_back('{id: 0, val: 32'hCCCC_0003});
      @(negedge clk_i);
      tick();
      mem_resp_valid_i = 1'b0;
      @(negedge clk_i);
      chk("s4_outst_end", 64'(outst_cnt_o), 64'(0));
      chk("s4_busy_end", 64'(busy_o), 64'(0));

      // Reset with one transaction in flight; late response is ignored.
      req_i[1].addr = 32'h5000;
      tick();
      req_valid_i = 2'b10;
      q_grant.push_back('{id: 1, val: 32'h5000});
      @(negedge clk_i);
      tick();
      rstn_i      = 1'b0;
      req_valid_i = 2'b11;
      @(negedge clk_i);
      chk("s5_rst_outst", 64'(outst_cnt_o), 64'(0));
      chk("s5_rst_busy", 64'(busy_o), 64'(0));
      chk("s5_rst_valid", 64'(mem_req_valid_o), 64'(0));
      chk("s5_rst_ready", 64'(req_ready_o), 64'(0));
      tick();
      rstn_i           = 1'b1;
      req_valid_i      = 2'b00;
      mem_resp_valid_i = 1'b1;
      mem_resp_i.rdata = 32'hDDDD_0004;
      @(negedge clk_i);
      chk("s5_late_resp_ready", 64'(mem_resp_ready_o), 64'(0));
      chk("s5_late_resp_valid", 64'(resp_valid_o), 64'(0));
      chk("s5_outst", 64'(outst_cnt_o), 64'(0));
      chk("s5_req_valid", 64'(mem_req_valid_o), 64'(0));
      tick();
      mem_resp_valid_i = 1'b0;
      @(negedge clk_i);

      chk("sb_grant_drained", 64'(q_grant.size()), 64'(0));
      chk("sb_resp_drained", 64'(q_resp.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates N requesters (serial debug port, core LSU, ...) onto one shared mem_req_t/mem_resp_t port.
- Round-robin grant with a stable grant while the downstream stalls.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.
- Sits between the requester masters and the single memory/bus slave port.

Parameters:
- N_REQ, 2, number of requesters; index 0 is the debug port.
- MAX_OUTST, 2, depth of the outstanding-ID FIFO; power of two, >=1.
- ID_W, $clog2(N_REQ) (min 1), requester-ID width (localparam).

Ports:
- clk_i  input  1  core clock; all logic on the rising edge.
- rstn_i  input  1  synchronous active-low reset.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester request accepted.
- req_i  input  mem_req_t[N_REQ]  per-requester request payload.
- resp_valid_o  output  N_REQ  per-requester response valid.
- resp_ready_i  input  N_REQ  per-requester response ready.
- resp_o  output  mem_resp_t  response payload, broadcast to all requesters.
- mem_req_valid_o  output  1  downstream request valid.
- mem_req_ready_i  input  1  downstream request ready.
- mem_req_o  output  mem_req_t  downstream request payload.
- mem_resp_valid_i  input  1  downstream response valid.
- mem_resp_ready_o  output  1  downstream response ready.
- mem_resp_i  input  mem_resp_t  downstream response payload.
- outst_cnt_o  output  $clog2(MAX_OUTST)+1  number of transactions in flight.
- busy_o  output  1  outst_cnt_o != 0 or a grant is held.

Behaviour:
- Reset (rstn_i low at a clock edge): FIFO empty, rr_ptr=0, state ARB_IDLE.
- Outputs in reset: all valid/ready outputs 0, outst_cnt_o=0, busy_o=0.
- A reset mid-transaction discards in-flight IDs; downstream responses that arrive later are not routed (mem_resp_ready_o=0 while FIFO empty).
- FSM ARB_IDLE:
  - If FIFO not full and any req_valid_i is set, pick a winner with a round-robin search starting at rr_ptr.
  - mem_req_valid_o=1, mem_req_o=req_i[win] combinationally.
  - If mem_req_ready_i=1: req_ready_o[win]=1, push win, rr_ptr<=win+1 (mod N_REQ), stay in ARB_IDLE. Zero-latency pass-through.
  - Else: register gnt_id<=win and go to ARB_HOLD.
- FSM ARB_HOLD:
  - mem_req_valid_o=1, mem_req_o=req_i[gnt_id]; no re-arbitration.
  - On mem_req_ready_i: req_ready_o[gnt_id]=1, push gnt_id, rr_ptr<=gnt_id+1, go to ARB_IDLE.
  - Requesters must hold valid and payload until ready. A dropped valid while in ARB_HOLD is a protocol violation; the RTL carries an assertion for it.
- FIFO full: no new grant (mem_req_valid_o=0) even if a pop happens in the same cycle. No ready-to-ready combinational path.
- Response routing: head = FIFO head ID.
  - resp_valid_o[head] = mem_resp_valid_i & !empty; all other resp_valid_o bits are 0.
  - mem_resp_ready_o = !empty & resp_ready_i[head].
  - Pop on mem_resp_valid_i & mem_resp_ready_o. resp_o = mem_resp_i unmodified.
- Ordering: the downstream returns responses in request order. Requests and responses of both read and write type occupy one FIFO entry each.
- Simultaneous push+pop: both take effect; outst_cnt_o is unchanged.
- Pointer arithmetic: rd/wr pointers wrap mod MAX_OUTST; count width covers 0..MAX_OUTST.

Optional Feature:
- Macro: MEM_ARB_DBG_PRIO_EN.
- Defined: requester 0 has absolute priority in ARB_IDLE, and rr_ptr is applied only among requesters 1..N_REQ-1. This guarantees debug access while the core saturates the bus.
- Undefined: plain round-robin over all N_REQ requesters.
- ARB_HOLD stability holds in both builds.

Decomposition:
- urv_typedef: mem_req_t and mem_resp_t are already present; add an arb_state_e enum (ARB_IDLE, ARB_HOLD).
- urv_cfg: MEM_ARB_N_REQ and MEM_ARB_MAX_OUTST defaults.
- Sub-module mem_arb_idfifo: sync FIFO of ID_W x MAX_OUTST with push/pop/full/empty/count. Reused for the outstanding tracking.

Test Plan:
- Single requester 1 read at addr 0x1000, ready=1, response one cycle later with data 0xDEADBEEF:
  - req_ready_o=2'b10 in the same cycle.
  - resp_valid_o=2'b10 with resp_data 0xDEADBEEF.
  - outst_cnt_o goes 0->1->0.
- Both valid every cycle, ready=1, responses immediate (default build): grants alternate 0,1,0,1 over 4 cycles and each response is routed to the matching requester.
- Requester 0 write, mem_req_ready_i low for 3 cycles while requester 1 raises valid:
  - Grant stays 0 and mem_req_o stays stable during the stall.
  - Requester 1 is granted the cycle after acceptance.
- Issue 2 requests (0 then 1) with responses withheld: a third request sees mem_req_valid_o=0 (full). Responses A then B route to 0 then 1. resp_ready_i[0]=0 stalls mem_resp_ready_o.
- MEM_ARB_DBG_PRIO_EN, both valid continuously: requester 0 is granted every cycle; requester 1 is granted only when requester 0 idles.
- Assert rstn_i with 1 outstanding: outst_cnt_o=0, all valids 0 next cycle, and a late mem_resp_valid_i is not acknowledged.
